// File: rtl/bin_to_bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, one bit per clock).
// Produces a leading-zero blanking mask and an over-range flag alongside the digits.
module bin_to_bcd #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [3:0]  blank,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state, w_next;
  logic [13:0] r_bin;
  logic [19:0] r_scr;
  logic [3:0]  r_cnt;

  logic [19:0] w_adj;
  logic [19:0] w_scr_next;
  logic [15:0] w_bcd;
  logic [3:0]  w_blank;
  logic        w_ovf;
  logic        w_last;

  assign w_last = (r_cnt == 4'd1);

  // Scratch holds five digits; the ten-thousands digit exists only to detect over-range.
  always_comb begin
    w_adj = r_scr;
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
    end
    w_scr_next = {w_adj[18:0], r_bin[13]};
    w_ovf      = (w_scr_next[19:16] != 4'd0) | w_adj[19];
    w_bcd      = (SATURATE && w_ovf) ? 16'h9999 : w_scr_next[15:0];
    w_blank[3] = (w_bcd[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (w_bcd[11:8] == 4'd0);
    w_blank[1] = w_blank[2] && (w_bcd[7:4] == 4'd0);
    w_blank[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin <= '0;
      r_scr <= '0;
      r_cnt <= '0;
      bcd   <= '0;
      blank <= 4'b1110;
      ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin <= bin;
            r_scr <= '0;
            r_cnt <= 4'd14;
          end
        end
        SHIFT: begin
          r_scr <= w_scr_next;
          r_bin <= {r_bin[12:0], 1'b0};
          r_cnt <= r_cnt - 4'd1;
          if (w_last) begin
            bcd   <= w_bcd;
            blank <= w_blank;
            ovf   <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd: saturating (default) and wrapping instances share stimulus.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [13:0] bin;

  logic        busy1, done1, ovf1;
  logic [15:0] bcd1;
  logic [3:0]  blank1;
  logic        busy0, done0, ovf0;
  logic [15:0] bcd0;
  logic [3:0]  blank0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd dut_sat (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .blank(blank1), .ovf(ovf1)
  );

  bin_to_bcd #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .bcd(bcd0), .blank(blank0), .ovf(ovf0)
  );

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [13:0] v);
    @(negedge clk); bin = v; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done1 !== 1'b1 && lat < 40) begin
      cycle();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bin = '0;
    cycle(); cycle();
    checks++;
    if ({busy1, done1, bcd1, blank1, ovf1} !== {1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL reset_sat: got busy=%b done=%b bcd=%h blank=%b ovf=%b, want 0 0 0000 1110 0",
               busy1, done1, bcd1, blank1, ovf1);
    end
    checks++;
    if ({busy0, done0, bcd0, blank0, ovf0} !== {1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL reset_wrap: got busy=%b done=%b bcd=%h blank=%b ovf=%b, want 0 0 0000 1110 0",
               busy0, done0, bcd0, blank0, ovf0);
    end
    @(negedge clk); reset = 1'b0;
    cycle();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL idle_hold: busy=%b want 0", busy1);
    end
  endtask

  task automatic test_basic();
    int lat;
    launch(14'd1234);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: busy=%b want 1", busy1);
    end
    wait_done(lat);
    checks++;
    if (lat != 14) begin
      errors++; $display("FAIL latency_1234: edges=%0d want 14", lat);
    end
    checks++;
    if ({bcd1, blank1, ovf1} !== {16'h1234, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL conv_1234: bcd=%h blank=%b ovf=%b want 1234 0000 0", bcd1, blank1, ovf1);
    end
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL busy_in_done: busy=%b want 1", busy1);
    end
    cycle();
    checks++;
    if ({done1, busy1} !== 2'b00) begin
      errors++; $display("FAIL done_one_cycle: done=%b busy=%b want 0 0", done1, busy1);
    end
    bin = 14'd5555;
    repeat (3) cycle();
    checks++;
    if ({bcd1, blank1, ovf1, done1} !== {16'h1234, 4'b0000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL hold_outputs: bcd=%h blank=%b ovf=%b done=%b want 1234 0000 0 0",
                         bcd1, blank1, ovf1, done1);
    end
  endtask

  task automatic test_patterns();
    logic [13:0] vin  [8] = '{14'd0, 14'd7, 14'd305, 14'd9999, 14'd10000, 14'd10005, 14'd12345, 14'd16383};
    logic [15:0] bs   [8] = '{16'h0000, 16'h0007, 16'h0305, 16'h9999, 16'h9999, 16'h9999, 16'h9999, 16'h9999};
    logic [3:0]  ks   [8] = '{4'b1110, 4'b1110, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [15:0] bw   [8] = '{16'h0000, 16'h0007, 16'h0305, 16'h9999, 16'h0000, 16'h0005, 16'h2345, 16'h6383};
    logic [3:0]  kw   [8] = '{4'b1110, 4'b1110, 4'b1000, 4'b0000, 4'b1110, 4'b1110, 4'b0000, 4'b0000};
    logic        ov   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      launch(vin[i]);
      wait_done(lat);
      checks++;
      if ({bcd1, blank1, ovf1} !== {bs[i], ks[i], ov[i]}) begin
        errors++; $display("FAIL pattern_sat_%0d: bcd=%h blank=%b ovf=%b want %h %b %b",
                           vin[i], bcd1, blank1, ovf1, bs[i], ks[i], ov[i]);
      end
      checks++;
      if ({bcd0, blank0, ovf0, done0} !== {bw[i], kw[i], ov[i], 1'b1}) begin
        errors++; $display("FAIL pattern_wrap_%0d: bcd=%h blank=%b ovf=%b done=%b want %h %b %b 1",
                           vin[i], bcd0, blank0, ovf0, done0, bw[i], kw[i], ov[i]);
      end
      cycle();
    end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    @(negedge clk); bin = 14'd42; start = 1'b1;
    cycle();
    wait_done(lat);
    checks++;
    if (lat != 14) begin
      errors++; $display("FAIL b2b_latency: edges=%0d want 14", lat);
    end
    checks++;
    if ({bcd1, blank1, ovf1} !== {16'h0042, 4'b1100, 1'b0}) begin
      errors++; $display("FAIL b2b_conv_42: bcd=%h blank=%b ovf=%b want 0042 1100 0", bcd1, blank1, ovf1);
    end
    cycle();
    n = 1;
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL b2b_start_in_done_ignored: busy=%b want 0", busy1);
    end
    while (done1 !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL b2b_spacing: done spacing=%0d want 16", n);
    end
    @(negedge clk); start = 1'b0;
    cycle(); cycle();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: busy=%b want 0", busy1);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit saw_done;
    launch(14'd4321);
    wait_done(lat);
    checks++;
    if ({bcd1, blank1, ovf1} !== {16'h4321, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL conv_4321: bcd=%h blank=%b ovf=%b want 4321 0000 0", bcd1, blank1, ovf1);
    end
    cycle();
    launch(14'd2222);
    saw_done = 1'b0;
    repeat (5) begin
      cycle();
      if (done1 === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk); reset = 1'b1;
    cycle();
    if (done1 === 1'b1) saw_done = 1'b1;
    checks++;
    if ({busy1, done1, bcd1, blank1, ovf1} !== {1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0}) begin
      errors++; $display("FAIL abort_reset_values: busy=%b done=%b bcd=%h blank=%b ovf=%b want 0 0 0000 1110 0",
                         busy1, done1, bcd1, blank1, ovf1);
    end
    @(negedge clk); reset = 1'b0; bin = 14'd1111; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL start_after_reset: busy=%b want 1", busy1);
    end
    wait_done(lat);
    checks++;
    if (saw_done || lat != 14) begin
      errors++; $display("FAIL abort_no_done: stray_done=%0d latency=%0d want 0 14", saw_done, lat);
    end
    checks++;
    if ({bcd1, blank1, ovf1} !== {16'h1111, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL conv_after_abort: bcd=%h blank=%b ovf=%b want 1111 0000 0", bcd1, blank1, ovf1);
    end
    cycle();
  endtask

  task automatic test_bin_change();
    int lat;
    launch(14'd100);
    @(negedge clk); bin = 14'd9000;
    wait_done(lat);
    checks++;
    if ({bcd1, blank1, ovf1} !== {16'h0100, 4'b1000, 1'b0}) begin
      errors++; $display("FAIL bin_change: bcd=%h blank=%b ovf=%b want 0100 1000 0", bcd1, blank1, ovf1);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_reset_abort();
    test_bin_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
